// File: rtl/ws2812_scheduler.sv
// ws2812_scheduler: shares the single ws2812 driver write port between a
// host requester (one LED per handshake) and a fill engine (one command
// expanded into consecutive per-LED writes). Sources alternate round-robin,
// with at most one driver write per clock.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   host_valid/host_ready      host handshake; host_ready depends on registers only
//   host_led_num, host_rgb     host target LED and GRB colour
//   fill_start                 one-cycle fill command strobe
//   fill_first, fill_last      inclusive fill range
//   fill_rgb                   fill colour
//   fill_busy, fill_done       fill in progress / completion pulse
//   write, led_num, rgb_data   registered driver write port
//   err                        out-of-range pulse (bounds checking only)
//
// Build option: define WS2812_SCHED_BOUNDS_CHECK_EN to reject or clamp indices
// >= leds; without it, indices pass through unchanged and err stays 0.
module ws2812_scheduler #(
    parameter int unsigned leds = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        host_valid,
    output logic        host_ready,
    input  logic [7:0]  host_led_num,
    input  logic [23:0] host_rgb,
    input  logic        fill_start,
    input  logic [7:0]  fill_first,
    input  logic [7:0]  fill_last,
    input  logic [23:0] fill_rgb,
    output logic        fill_busy,
    output logic        fill_done,
    output logic        write,
    output logic [7:0]  led_num,
    output logic [23:0] rgb_data,
    output logic        err
);

    localparam int unsigned IDX_W = 8;
    localparam int unsigned RGB_W = 24;

    // The chain length must be addressable with an 8-bit index.
    if (leds < 1 || leds > 256) begin : g_bad_leds
        $error("ws2812_scheduler: leds must be in 1..256");
    end

    typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_e;
    typedef enum logic {GNT_HOST = 1'b0, GNT_FILL = 1'b1} src_e;

    state_e             state_q, state_d;
    src_e               last_grant_q, last_grant_d;
    logic [IDX_W-1:0]   cur_q, cur_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [RGB_W-1:0]   colour_q, colour_d;
    logic               write_q, write_d;
    logic [IDX_W-1:0]   led_num_q, led_num_d;
    logic [RGB_W-1:0]   rgb_data_q, rgb_data_d;
    logic               fill_done_q, fill_done_d;
    logic               err_q, err_d;

    logic               grant_host;
    logic               grant_fill;
    logic               host_oob;
    logic               first_oob;
    logic               last_clamp;
    logic [IDX_W-1:0]   fill_last_eff;

`ifdef WS2812_SCHED_BOUNDS_CHECK_EN
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(leds - 1);

    assign host_oob      = (host_led_num > LAST_IDX);
    assign first_oob     = (fill_first > LAST_IDX);
    assign last_clamp    = (fill_last > LAST_IDX);
    assign fill_last_eff = last_clamp ? LAST_IDX : fill_last;
`else
    assign host_oob      = 1'b0;
    assign first_oob     = 1'b0;
    assign last_clamp    = 1'b0;
    assign fill_last_eff = fill_last;
`endif

    // Host wins whenever idle, otherwise only after a fill grant (alternation).
    assign host_ready = !reset && ((state_q == IDLE) || (last_grant_q == GNT_FILL));
    assign grant_host = host_valid && host_ready;
    assign grant_fill = (state_q == FILL) && !grant_host;

    // Next-state, grant and driver-port logic.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cur_d        = cur_q;
        last_d       = last_q;
        colour_d     = colour_q;
        write_d      = 1'b0;
        led_num_d    = led_num_q;
        rgb_data_d   = rgb_data_q;
        fill_done_d  = 1'b0;
        err_d        = 1'b0;

        if (grant_host) begin
            last_grant_d = GNT_HOST;
            if (host_oob) begin
                err_d = 1'b1;
            end else begin
                write_d    = 1'b1;
                led_num_d  = host_led_num;
                rgb_data_d = host_rgb;
            end
        end else if (grant_fill) begin
            last_grant_d = GNT_FILL;
            write_d      = 1'b1;
            led_num_d    = cur_q;
            rgb_data_d   = colour_q;
            // Compare before incrementing so a range ending at 255 never wraps.
            if (cur_q == last_q) begin
                state_d     = IDLE;
                fill_done_d = 1'b1;
            end else begin
                cur_d = cur_q + IDX_W'(1);
            end
        end

        // Fill commands are only accepted while idle; may coincide with a host grant.
        if ((state_q == IDLE) && fill_start) begin
            if (first_oob) begin
                fill_done_d = 1'b1;
                err_d       = 1'b1;
            end else if (fill_first > fill_last_eff) begin
                fill_done_d = 1'b1;
            end else begin
                state_d  = FILL;
                cur_d    = fill_first;
                last_d   = fill_last_eff;
                colour_d = fill_rgb;
                if (last_clamp) begin
                    err_d = 1'b1;
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_FILL;
            cur_q        <= '0;
            last_q       <= '0;
            colour_q     <= '0;
            write_q      <= 1'b0;
            led_num_q    <= '0;
            rgb_data_q   <= '0;
            fill_done_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cur_q        <= cur_d;
            last_q       <= last_d;
            colour_q     <= colour_d;
            write_q      <= write_d;
            led_num_q    <= led_num_d;
            rgb_data_q   <= rgb_data_d;
            fill_done_q  <= fill_done_d;
            err_q        <= err_d;
        end
    end

    assign fill_busy = (state_q == FILL);
    assign fill_done = fill_done_q;
    assign write     = write_q;
    assign led_num   = led_num_q;
    assign rgb_data  = rgb_data_q;
    assign err       = err_q;

endmodule

// File: tb/tb_ws2812_scheduler.sv
// Directed bench for ws2812_scheduler: host writes, fills, round-robin
// contention, range boundaries, reset mid-fill and (when built with
// WS2812_SCHED_BOUNDS_CHECK_EN) index range checking.
module tb_ws2812_scheduler;

    localparam int unsigned LEDS = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        host_valid;
    logic        host_ready;
    logic [7:0]  host_led_num;
    logic [23:0] host_rgb;
    logic        fill_start;
    logic [7:0]  fill_first;
    logic [7:0]  fill_last;
    logic [23:0] fill_rgb;
    logic        fill_busy;
    logic        fill_done;
    logic        write;
    logic [7:0]  led_num;
    logic [23:0] rgb_data;
    logic        err;

    int n_vec = 0;
    int n_err = 0;

    ws2812_scheduler #(.leds(LEDS)) dut (
        .clk          (clk),
        .reset        (reset),
        .host_valid   (host_valid),
        .host_ready   (host_ready),
        .host_led_num (host_led_num),
        .host_rgb     (host_rgb),
        .fill_start   (fill_start),
        .fill_first   (fill_first),
        .fill_last    (fill_last),
        .fill_rgb     (fill_rgb),
        .fill_busy    (fill_busy),
        .fill_done    (fill_done),
        .write        (write),
        .led_num      (led_num),
        .rgb_data     (rgb_data),
        .err          (err)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_fill(input logic [7:0] first, input logic [7:0] last,
                              input logic [23:0] rgb);
        fill_start = 1'b1;
        fill_first = first;
        fill_last  = last;
        fill_rgb   = rgb;
    endtask

    initial begin
        reset        = 1'b1;
        host_valid   = 1'b0;
        host_led_num = 8'd0;
        host_rgb     = 24'd0;
        fill_start   = 1'b0;
        fill_first   = 8'd0;
        fill_last    = 8'd0;
        fill_rgb     = 24'd0;

        // Reset state
        repeat (10) tick();
        chk("rst_write",     32'(write),      32'd0);
        chk("rst_led_num",   32'(led_num),    32'd0);
        chk("rst_rgb",       32'(rgb_data),   32'd0);
        chk("rst_busy",      32'(fill_busy),  32'd0);
        chk("rst_done",      32'(fill_done),  32'd0);
        chk("rst_err",       32'(err),        32'd0);
        chk("rst_ready",     32'(host_ready), 32'd0);
        reset = 1'b0;
        tick();
        chk("idle_ready",    32'(host_ready), 32'd1);
        chk("idle_write",    32'(write),      32'd0);

        // Host-only write: LED 1 = 0xAABBCC
        host_valid   = 1'b1;
        host_led_num = 8'd1;
        host_rgb     = 24'hAABBCC;
        #1;
        chk("host_ready",    32'(host_ready), 32'd1);
        tick();
        host_valid = 1'b0;
        chk("host_write",    32'(write),      32'd1);
        chk("host_led",      32'(led_num),    32'd1);
        chk("host_rgb",      32'(rgb_data),   32'hAABBCC);
        tick();
        chk("host_wr_off",   32'(write),      32'd0);
        chk("host_led_hold", 32'(led_num),    32'd1);
        chk("host_rgb_hold", 32'(rgb_data),   32'hAABBCC);

        // Fill only: 2..5 = 0x00FF00
        start_fill(8'd2, 8'd5, 24'h00FF00);
        tick();
        fill_start = 1'b0;
        chk("fill_busy_n1",  32'(fill_busy),  32'd1);
        chk("fill_wr_n1",    32'(write),      32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("fill_write",  32'(write),     32'd1);
            chk("fill_led",    32'(led_num),   32'(2 + i));
            chk("fill_rgb",    32'(rgb_data),  32'h00FF00);
            chk("fill_busy",   32'(fill_busy), (i < 3) ? 32'd1 : 32'd0);
            chk("fill_done",   32'(fill_done), (i == 3) ? 32'd1 : 32'd0);
        end
        tick();
        chk("fill_wr_end",   32'(write),      32'd0);
        chk("fill_done_end", 32'(fill_done),  32'd0);

        // Contention: fill 0..3 (0x0000FF) against continuous host LED 7 (0x123456)
        host_valid   = 1'b1;
        host_led_num = 8'd7;
        host_rgb     = 24'h123456;
        start_fill(8'd0, 8'd3, 24'h0000FF);
        tick();
        fill_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("ct_write",  32'(write),      32'd1);
            chk("ct_led",    32'(led_num),    (k % 2 == 0) ? 32'd7 : 32'(k / 2));
            chk("ct_rgb",    32'(rgb_data),   (k % 2 == 0) ? 32'h123456 : 32'h0000FF);
            chk("ct_done",   32'(fill_done),  (k == 7) ? 32'd1 : 32'd0);
            chk("ct_ready",  32'(host_ready), ((k % 2 == 1) || (k == 7)) ? 32'd1 : 32'd0);
            tick();
        end
        chk("ct_after_busy", 32'(fill_busy),  32'd0);
        chk("ct_after_led",  32'(led_num),    32'd7);
        chk("ct_after_wr",   32'(write),      32'd1);
        host_valid = 1'b0;
        tick();
        tick();
        chk("ct_quiet",      32'(write),      32'd0);

        // Boundary: inverted range is ignored, fill_done next cycle
        start_fill(8'd3, 8'd1, 24'h777777);
        tick();
        fill_start = 1'b0;
        chk("inv_done",      32'(fill_done),  32'd1);
        chk("inv_busy",      32'(fill_busy),  32'd0);
        chk("inv_write",     32'(write),      32'd0);
        tick();
        chk("inv_done_off",  32'(fill_done),  32'd0);
        chk("inv_write2",    32'(write),      32'd0);

`ifndef WS2812_SCHED_BOUNDS_CHECK_EN
        // Boundary: 254..255 writes twice and stops without wrapping
        start_fill(8'd254, 8'd255, 24'hABCDEF);
        tick();
        fill_start = 1'b0;
        chk("top_busy",      32'(fill_busy),  32'd1);
        tick();
        chk("top_led0",      32'(led_num),    32'd254);
        chk("top_wr0",       32'(write),      32'd1);
        tick();
        chk("top_led1",      32'(led_num),    32'd255);
        chk("top_wr1",       32'(write),      32'd1);
        chk("top_done",      32'(fill_done),  32'd1);
        chk("top_busy_off",  32'(fill_busy),  32'd0);
        tick();
        chk("top_nowrap_wr", 32'(write),      32'd0);
        chk("top_led_hold",  32'(led_num),    32'd255);
        tick();
        chk("top_nowrap_wr2", 32'(write),     32'd0);
`endif

        // Reset mid-fill: 0..7, reset after three writes
        start_fill(8'd0, 8'd7, 24'h0F0F0F);
        tick();
        fill_start = 1'b0;
        repeat (3) tick();
        chk("mid_led2",      32'(led_num),    32'd2);
        reset = 1'b1;
        tick();
        chk("mid_rst_wr",    32'(write),      32'd0);
        chk("mid_rst_led",   32'(led_num),    32'd0);
        chk("mid_rst_rgb",   32'(rgb_data),   32'd0);
        chk("mid_rst_busy",  32'(fill_busy),  32'd0);
        chk("mid_rst_done",  32'(fill_done),  32'd0);
        chk("mid_rst_ready", 32'(host_ready), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("mid_post_wr",   32'(write),     32'd0);
            chk("mid_post_done", 32'(fill_done), 32'd0);
        end

`ifdef WS2812_SCHED_BOUNDS_CHECK_EN
        // Host LED 9 is out of range: handshake without a write
        host_valid   = 1'b1;
        host_led_num = 8'd9;
        host_rgb     = 24'h112233;
        tick();
        host_valid = 1'b0;
        chk("bc_host_wr",    32'(write),      32'd0);
        chk("bc_host_err",   32'(err),        32'd1);
        tick();
        chk("bc_host_err0",  32'(err),        32'd0);

        // Fill 6..20 clamps to 6..7
        start_fill(8'd6, 8'd20, 24'h010203);
        tick();
        fill_start = 1'b0;
        chk("bc_fill_err",   32'(err),        32'd1);
        chk("bc_fill_busy",  32'(fill_busy),  32'd1);
        tick();
        chk("bc_fill_led6",  32'(led_num),    32'd6);
        chk("bc_fill_err0",  32'(err),        32'd0);
        tick();
        chk("bc_fill_led7",  32'(led_num),    32'd7);
        chk("bc_fill_done",  32'(fill_done),  32'd1);
        tick();
        chk("bc_fill_end",   32'(write),      32'd0);
`else
        // Without bounds checking, indices pass through unchanged
        host_valid   = 1'b1;
        host_led_num = 8'd9;
        host_rgb     = 24'h112233;
        tick();
        host_valid = 1'b0;
        chk("pt_host_wr",    32'(write),      32'd1);
        chk("pt_host_led",   32'(led_num),    32'd9);
        chk("pt_host_err",   32'(err),        32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
